// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus: default widths, slave FSM
// states and the frame operation encoding.
package bus_pkg;

  localparam int DEF_ADDR_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BURST_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WDATA,
    WMEM,
    RREQ,
    RWAIT,
    RDATA,
    DONE
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register: serial bits enter at the MSB, so an LSB-first stream
// is fully assembled after WIDTH shifts and data[0] is the next bit to send.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {shift_in, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_port.sv
// Slave end of the bit-serial bus: deserialises header and write data, drives a
// single-port local memory, and serialises read data back to the master.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  master_valid,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  rx_address,
  input  logic                  rx_burst_num,
  input  logic                  rx_data,
  output logic                  slave_ready,
  output logic                  slave_valid,
  output logic                  tx_data,
  output logic                  rx_done,
  output logic                  tx_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DAT_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] BURST_BITS = CNT_W'(BURST_WIDTH);

  state_t                 state;
  op_t                    op;
  logic [CNT_W-1:0]       bit_cnt;
  logic [BURST_WIDTH-1:0] beat;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rd_q;

  logic start;
  logic hdr_acc;
  logic burst_acc;
  logic wdata_acc;
  logic last_beat;
  logic unused_rd_hi;

  assign start     = sel & master_valid & (write_en ^ read_en);
  assign hdr_acc   = (state == IDLE && start) || (state == HEADER && master_valid);
  // Burst bits ride alongside only the low BURST_WIDTH address bits.
  assign burst_acc = hdr_acc && (bit_cnt < BURST_BITS);
  assign wdata_acc = (state == WDATA) && master_valid;
  assign last_beat = (beat == burst_q);

  // Beat address wraps naturally at the ADDR_WIDTH boundary.
  assign mem_addr  = addr_q + ADDR_WIDTH'(beat);
  assign mem_wdata = wdata_q;
  assign tx_data   = slave_valid & rd_q[0];

  assign unused_rd_hi = ^rd_q[DATA_WIDTH-1:1];

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (hdr_acc),
    .shift_in  (rx_address),
    .data      (addr_q)
  );

  serial_shift_reg #(.WIDTH(BURST_WIDTH)) u_burst (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (burst_acc),
    .shift_in  (rx_burst_num),
    .data      (burst_q)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (wdata_acc),
    .shift_in  (rx_data),
    .data      (wdata_q)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata (
    .clk       (clk),
    .reset     (reset),
    .load      (state == RWAIT),
    .load_data (mem_rdata),
    .shift_en  (state == RDATA),
    .shift_in  (1'b0),
    .data      (rd_q)
  );

  // Outputs are registered: each transition sets the strobes of the state it enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op          <= OP_WRITE;
      bit_cnt     <= '0;
      beat        <= '0;
      slave_ready <= 1'b1;
      slave_valid <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rx_done     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      slave_ready <= 1'b0;
      slave_valid <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rx_done     <= 1'b0;
      tx_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op      <= write_en ? OP_WRITE : OP_READ;
            bit_cnt <= CNT_W'(1);
            beat    <= '0;
            state   <= HEADER;
          end else begin
            slave_ready <= 1'b1;
          end
        end
        HEADER: begin
          if (master_valid) begin
            if (bit_cnt == HDR_LAST) begin
              bit_cnt <= '0;
              beat    <= '0;
              if (op == OP_WRITE) begin
                state <= WDATA;
              end else begin
                state  <= RREQ;
                mem_re <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        WDATA: begin
          if (master_valid) begin
            if (bit_cnt == DAT_LAST) begin
              bit_cnt <= '0;
              state   <= WMEM;
              mem_we  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        WMEM: begin
          if (last_beat) begin
            state   <= DONE;
            rx_done <= 1'b1;
          end else begin
            beat  <= beat + 1'b1;
            state <= WDATA;
          end
        end
        RREQ: begin
          state <= RWAIT;
        end
        RWAIT: begin
          state       <= RDATA;
          slave_valid <= 1'b1;
        end
        RDATA: begin
          if (bit_cnt == DAT_LAST) begin
            bit_cnt <= '0;
            if (last_beat) begin
              state   <= DONE;
              tx_done <= 1'b1;
            end else begin
              beat   <= beat + 1'b1;
              state  <= RREQ;
              mem_re <= 1'b1;
            end
          end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            slave_valid <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: stimulus pushes cycle-exact expected memory
// strobes, read bits and completions; a negedge monitor pops and compares.
module tb_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 12;
  localparam int GAP = DW + 2;

  logic          clk;
  logic          reset;
  logic          sel;
  logic          master_valid;
  logic          write_en;
  logic          read_en;
  logic          rx_address;
  logic          rx_burst_num;
  logic          rx_data;
  logic          slave_ready;
  logic          slave_valid;
  logic          tx_data;
  logic          rx_done;
  logic          tx_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sel          (sel),
    .master_valid (master_valid),
    .write_en     (write_en),
    .read_en      (read_en),
    .rx_address   (rx_address),
    .rx_burst_num (rx_burst_num),
    .rx_data      (rx_data),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .tx_data      (tx_data),
    .rx_done      (rx_done),
    .tx_done      (tx_done),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata)
  );

  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  typedef struct { int cyc; logic b; } bit_t;
  typedef struct { int cyc; logic is_wr; } done_t;

  wr_t   wr_q[$];
  rd_t   rd_q[$];
  bit_t  bit_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_due = -1;
  int last_done_cyc = -1;
  bit mon_on = 0;

  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] dmem    [1 << AW];
  bit            dvalid  [1 << AW];

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 37 + 5);
  endfunction

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Local memory seen by the DUT: 1-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_addr]   <= mem_wdata;
      dvalid[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= dvalid[mem_addr] ? dmem[mem_addr] : init_val(int'(mem_addr));
    else        mem_rdata <= DW'($urandom);
  end

  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    bit_t b;
    done_t d;
    if (mon_on) begin
      if (mem_we && mem_re) begin
        checks++; errors++;
        $display("FAIL strobe_overlap cyc=%0d we=1 re=1 required never both", cyc);
      end
      if (mem_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++; $display("FAIL unexpected_we cyc=%0d addr=%h data=%h required none", cyc, mem_addr, mem_wdata);
        end else begin
          w = wr_q.pop_front();
          if (cyc != w.cyc || mem_addr !== w.addr || mem_wdata !== w.data) begin
            errors++;
            $display("FAIL mem_write cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                     cyc, mem_addr, mem_wdata, w.cyc, w.addr, w.data);
          end
        end
      end
      if (mem_re) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++; $display("FAIL unexpected_re cyc=%0d addr=%h required none", cyc, mem_addr);
        end else begin
          r = rd_q.pop_front();
          if (cyc != r.cyc || mem_addr !== r.addr) begin
            errors++;
            $display("FAIL mem_read cyc=%0d addr=%h required cyc=%0d addr=%h", cyc, mem_addr, r.cyc, r.addr);
          end
        end
      end
      if (slave_valid) begin
        checks++;
        if (bit_q.size() == 0) begin
          errors++; $display("FAIL unexpected_valid cyc=%0d tx=%b required none", cyc, tx_data);
        end else begin
          b = bit_q.pop_front();
          if (cyc != b.cyc || tx_data !== b.b) begin
            errors++;
            $display("FAIL tx_bit cyc=%0d tx=%b required cyc=%0d tx=%b", cyc, tx_data, b.cyc, b.b);
          end
        end
      end
      if (rx_done || tx_done) begin
        checks++;
        last_done_cyc = cyc;
        ready_due = cyc + 1;
        if (done_q.size() == 0) begin
          errors++; $display("FAIL unexpected_done cyc=%0d rx=%b tx=%b required none", cyc, rx_done, tx_done);
        end else begin
          d = done_q.pop_front();
          if (cyc != d.cyc || rx_done !== d.is_wr || tx_done !== !d.is_wr) begin
            errors++;
            $display("FAIL done cyc=%0d rx=%b tx=%b required cyc=%0d rx=%b tx=%b",
                     cyc, rx_done, tx_done, d.cyc, d.is_wr, !d.is_wr);
          end
        end
      end else if (cyc == ready_due) begin
        checks++;
        if (slave_ready !== 1'b1) begin
          errors++; $display("FAIL ready_after_done cyc=%0d ready=%b required 1", cyc, slave_ready);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    sel = 1'($urandom); master_valid = 1'($urandom);
    write_en = 1'($urandom); read_en = 1'($urandom);
    rx_address = 1'($urandom); rx_burst_num = 1'($urandom); rx_data = 1'($urandom);
    tick();
  endtask

  // Idle-bus patterns that must never start a frame.
  task automatic idle_drive();
    int p = $urandom_range(0, 3);
    rx_address = 1'($urandom); rx_burst_num = 1'($urandom); rx_data = 1'($urandom);
    case (p)
      0: begin sel = 1'($urandom); master_valid = 0; write_en = 1'($urandom); read_en = 1'($urandom); end
      1: begin sel = 0; master_valid = 1; write_en = 1'($urandom); read_en = 1'($urandom); end
      2: begin sel = 1; master_valid = 1; write_en = 1; read_en = 1; end
      default: begin sel = 1; master_valid = 1; write_en = 0; read_en = 0; end
    endcase
    tick();
  endtask

  function automatic int nstall(input int idx, input int at, input int len, input bit rnd);
    if (idx == at) return len;
    if (rnd && $urandom_range(0, 4) == 0) return $urandom_range(1, 3);
    return 0;
  endfunction

  task automatic stall_cycle(input bit is_wr);
    sel = 1; master_valid = 0; write_en = is_wr; read_en = !is_wr;
    rx_address = 1'($urandom); rx_burst_num = 1'($urandom); rx_data = 1'($urandom);
    tick();
  endtask

  task automatic run_frame(input bit is_wr, input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                           input logic [DW-1:0] data [4], input int hs_at, input int hs_len,
                           input int ds_at, input int ds_len, input bit rnd, input int abort_beat,
                           output int t_start);
    int th, td, nb;
    logic [AW-1:0] ba;
    nb = int'(burst) + 1;
    t_start = cyc;
    for (int i = 0; i < AW; i++) begin
      if (i > 0) repeat (nstall(i, hs_at, hs_len, rnd)) stall_cycle(is_wr);
      sel = 1; master_valid = 1; write_en = is_wr; read_en = !is_wr;
      rx_address = addr[i];
      rx_burst_num = (i < BW) ? burst[i] : 1'($urandom);
      rx_data = 1'($urandom);
      th = cyc;
      tick();
    end
    if (is_wr) begin
      td = th;
      for (int b = 0; b < nb; b++) begin
        ba = addr + AW'(b);
        for (int k = 0; k < DW; k++) begin
          if (b == abort_beat && k == 3) begin
            reset = 1; sel = 0; master_valid = 0;
            tick(); tick();
            reset = 0;
            chk("ready_after_reset0", int'(slave_ready), 1);
            tick();
            chk("ready_after_reset1", int'(slave_ready), 1);
            return;
          end
          repeat (nstall(b * DW + k, ds_at, ds_len, rnd)) stall_cycle(is_wr);
          sel = 1; master_valid = 1; write_en = is_wr; read_en = !is_wr;
          rx_address = 1'($urandom); rx_burst_num = 1'($urandom);
          rx_data = data[b][k];
          td = cyc;
          tick();
        end
        wr_q.push_back('{td + 1, ba, data[b]});
        ref_mem[ba] = data[b];
        if (b == nb - 1) done_q.push_back('{td + 2, 1'b1});
        junk();
      end
      junk();
    end else begin
      for (int b = 0; b < nb; b++) begin
        ba = addr + AW'(b);
        rd_q.push_back('{th + 1 + b * GAP, ba});
        for (int k = 0; k < DW; k++) bit_q.push_back('{th + 3 + b * GAP + k, ref_mem[ba][k]});
      end
      done_q.push_back('{th + 1 + nb * GAP, 1'b0});
      repeat (nb * GAP + 1) junk();
    end
  endtask

  initial begin
    logic [DW-1:0] beats [4];
    int s1, d1, s2, d2, ts;
    bit wr;
    logic [AW-1:0] a;
    logic [BW-1:0] bn;

    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i] = init_val(i);
      dvalid[i] = 1'b0;
    end
    reset = 1; sel = 0; master_valid = 0; write_en = 0; read_en = 0;
    rx_address = 0; rx_burst_num = 0; rx_data = 0;
    repeat (3) tick();
    reset = 0;
    chk("reset_ready", int'(slave_ready), 1);
    chk("reset_valid", int'(slave_valid), 0);
    chk("reset_tx", int'(tx_data), 0);
    chk("reset_done", int'({rx_done, tx_done}), 0);
    chk("reset_strobes", int'({mem_we, mem_re}), 0);
    chk("reset_addr", int'(mem_addr), 0);
    chk("reset_wdata", int'(mem_wdata), 0);
    mon_on = 1;
    tick();

    // Single write, then the same write with 3-cycle stalls in header and data.
    beats = '{8'hBD, 8'h00, 8'h00, 8'h00};
    run_frame(1, 12'hADD, 12'd0, beats, -1, 0, -1, 0, 0, -1, s1);
    d1 = last_done_cyc;
    idle_drive();
    run_frame(1, 12'hADD, 12'd0, beats, 6, 3, 4, 3, 0, -1, s2);
    d2 = last_done_cyc;
    chk("stall_delay", (d2 - s2) - (d1 - s1), 6);
    idle_drive();

    // Burst write wrapping past the top of the address space.
    beats = '{8'h11, 8'h22, 8'h33, 8'h00};
    run_frame(1, 12'hFFE, 12'd2, beats, -1, 0, -1, 0, 0, -1, ts);

    // Read burst from 0x010 after placing 0x5A, 0xC3 there.
    beats = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    run_frame(1, 12'h010, 12'd1, beats, -1, 0, -1, 0, 0, -1, ts);
    run_frame(0, 12'h010, 12'd1, beats, -1, 0, -1, 0, 0, -1, ts);
    run_frame(0, 12'hFFE, 12'd2, beats, -1, 0, -1, 0, 0, -1, ts);

    // Illegal and unselected bus activity while idle.
    for (int i = 0; i < 12; i++) begin
      idle_drive();
      chk("ready_idle", int'(slave_ready), 1);
    end

    // Reset during beat 1 of a 3-beat write, then a clean single write.
    beats = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
    run_frame(1, 12'h200, 12'd2, beats, -1, 0, -1, 0, 0, 1, ts);
    beats = '{8'h7E, 8'h00, 8'h00, 8'h00};
    run_frame(1, 12'h300, 12'd0, beats, -1, 0, -1, 0, 0, -1, ts);
    run_frame(0, 12'h200, 12'd2, beats, -1, 0, -1, 0, 0, -1, ts);

    // Randomized mix of writes and reads with random stalls and idle noise.
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom);
      a = ($urandom_range(0, 2) == 0) ? AW'(12'hFFC + $urandom_range(0, 3)) : AW'($urandom);
      bn = BW'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) beats[j] = DW'($urandom);
      run_frame(wr, a, bn, beats, -1, 0, -1, 0, 1, -1, ts);
      repeat ($urandom_range(0, 3)) idle_drive();
    end

    for (int i = 0; i < 200 && (wr_q.size() + rd_q.size() + bit_q.size() + done_q.size()) != 0; i++)
      idle_drive();
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_reads", rd_q.size(), 0);
    chk("pending_bits", bit_q.size(), 0);
    chk("pending_done", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
